// File: rtl/id_decode_pipe_if.sv
// Bus bundle between IF, the decode stage, the register file and EX.
// The slave modport is the decode stage; the master modport is its environment.
// When ID_ILLEGAL_DET_EN is defined the bundle also carries out_illegal.
interface id_decode_pipe_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [XLEN-1:0]  in_pc;
    logic [4:0]       rf_rs1;
    logic [4:0]       rf_rs2;
    logic [XLEN-1:0]  rf_rdata1;
    logic [XLEN-1:0]  rf_rdata2;
    logic             ex_valid;
    logic [4:0]       ex_rd;
    logic [1:0]       ex_wb_sel;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [4:0]       out_rd;
    logic [XLEN-1:0]  out_opr_a;
    logic [XLEN-1:0]  out_opr_b;
    logic [XLEN-1:0]  out_imm;
    logic [XLEN-1:0]  out_pc;
    logic [XLEN-1:0]  out_pc4;
    logic             out_rf_en;
    logic             out_dm_en;
    logic             out_is_load;
    logic             out_is_branch;
    logic             out_is_jump;
    logic [2:0]       out_funct3;
    logic [6:0]       out_opcode;
    logic [CNT_W-1:0] stall_cnt;
`ifdef ID_ILLEGAL_DET_EN
    logic             out_illegal;
`endif

    modport slave (
        input  in_valid, in_inst, in_pc, rf_rdata1, rf_rdata2,
               ex_valid, ex_rd, ex_wb_sel, flush, out_ready,
        output in_ready, rf_rs1, rf_rs2, out_valid, out_rs1, out_rs2, out_rd,
               out_opr_a, out_opr_b, out_imm, out_pc, out_pc4,
               out_rf_en, out_dm_en, out_is_load, out_is_branch, out_is_jump,
               out_funct3, out_opcode, stall_cnt
`ifdef ID_ILLEGAL_DET_EN
             , out_illegal
`endif
    );

    modport master (
        output in_valid, in_inst, in_pc, rf_rdata1, rf_rdata2,
               ex_valid, ex_rd, ex_wb_sel, flush, out_ready,
        input  in_ready, rf_rs1, rf_rs2, out_valid, out_rs1, out_rs2, out_rd,
               out_opr_a, out_opr_b, out_imm, out_pc, out_pc4,
               out_rf_en, out_dm_en, out_is_load, out_is_branch, out_is_jump,
               out_funct3, out_opcode, stall_cnt
`ifdef ID_ILLEGAL_DET_EN
             , out_illegal
`endif
    );
endinterface

// File: rtl/id_decode_pipe.sv
// Registered RV32I/RV64I decode stage: immediate generation, control decode,
// load-use hazard bubbles, valid/ready output register, saturating stall counter.
// Optional: define ID_ILLEGAL_DET_EN to add out_illegal and suppress rf_en/dm_en
// for unrecognised encodings.
module id_decode_pipe #(
    parameter int         XLEN    = 32,
    parameter logic [1:0] WB_LOAD = 2'b10,
    parameter int         CNT_W   = 16
) (
    input logic          clk,
    input logic          arst_n,
    id_decode_pipe_if.slave bus
);
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_OPIMM   = 7'b0010011;
    localparam logic [6:0] OP_OP      = 7'b0110011;
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OP_OP32    = 7'b0111011;
    localparam logic       RV64       = (XLEN == 64);

    typedef struct packed {
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] opr_a;
        logic [XLEN-1:0] opr_b;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic            rf_en;
        logic            dm_en;
        logic            is_load;
        logic            is_branch;
        logic            is_jump;
        logic [2:0]      funct3;
        logic [6:0]      opcode;
    } dec_t;

    logic [31:0]      inst;
    logic [6:0]       opcode;
    logic [4:0]       rs1, rs2, rd;
    logic             known;
    logic             uses_rs1, uses_rs2;
    logic [31:0]      imm32;
    logic             hazard;
    logic             adv;
    logic             in_ready;
    logic             accept;
    dec_t             dec_d, dec_q;
    logic             out_valid_q;
    logic [CNT_W-1:0] cnt_q;
`ifdef ID_ILLEGAL_DET_EN
    logic             illegal_d, illegal_q;
`endif

    assign inst   = bus.in_inst;
    assign opcode = inst[6:0];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign rd     = inst[11:7];

    // Immediate format selection and opcode recognition.
    always_comb begin
        known = 1'b0;
        imm32 = '0;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                known = 1'b1;
                imm32 = {inst[31:12], 12'b0};
            end
            OP_JAL: begin
                known = 1'b1;
                imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            OP_JALR, OP_LOAD, OP_OPIMM: begin
                known = 1'b1;
                imm32 = {{20{inst[31]}}, inst[31:20]};
            end
            OP_OPIMM32: begin
                // Word ops only exist on RV64; on RV32 they fall through as unknown.
                known = RV64;
                imm32 = RV64 ? {{20{inst[31]}}, inst[31:20]} : 32'b0;
            end
            OP_STORE: begin
                known = 1'b1;
                imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OP_BRANCH: begin
                known = 1'b1;
                imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OP_OP:   known = 1'b1;
            OP_OP32: known = RV64;
            default: ;
        endcase
    end

    assign uses_rs1 = !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
    assign uses_rs2 = opcode inside {OP_OP, OP_OP32, OP_STORE, OP_BRANCH};

    assign hazard = bus.in_valid & bus.ex_valid & (bus.ex_wb_sel == WB_LOAD) &
                    (bus.ex_rd != 5'd0) &
                    ((uses_rs1 & (bus.ex_rd == rs1)) | (uses_rs2 & (bus.ex_rd == rs2)));
    assign adv      = ~out_valid_q | bus.out_ready;
    assign in_ready = adv & ~hazard & ~bus.flush;
    assign accept   = bus.in_valid & in_ready;

    // Assemble the record that the output register captures on accept.
    always_comb begin
        dec_d           = '0;
        dec_d.rs1       = rs1;
        dec_d.rs2       = rs2;
        dec_d.rd        = rd;
        dec_d.opr_a     = bus.rf_rdata1;
        dec_d.opr_b     = bus.rf_rdata2;
        dec_d.imm       = XLEN'($signed(imm32));
        dec_d.pc        = bus.in_pc;
        dec_d.pc4       = bus.in_pc + XLEN'(4);
        dec_d.rf_en     = known & (opcode != OP_STORE) & (opcode != OP_BRANCH) & (rd != 5'd0);
        dec_d.dm_en     = (opcode == OP_LOAD) | (opcode == OP_STORE);
        dec_d.is_load   = (opcode == OP_LOAD);
        dec_d.is_branch = (opcode == OP_BRANCH);
        dec_d.is_jump   = (opcode == OP_JAL) | (opcode == OP_JALR);
        dec_d.funct3    = inst[14:12];
        dec_d.opcode    = opcode;
`ifdef ID_ILLEGAL_DET_EN
        illegal_d = ~known | (inst[1:0] != 2'b11);
        if (illegal_d) begin
            dec_d.rf_en = 1'b0;
            dec_d.dm_en = 1'b0;
        end
`endif
    end

    // Output register: flush kills, accept loads, an idle advance bubbles, else hold.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            out_valid_q <= 1'b0;
            dec_q       <= '0;
`ifdef ID_ILLEGAL_DET_EN
            illegal_q   <= 1'b0;
`endif
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            dec_q       <= dec_d;
`ifdef ID_ILLEGAL_DET_EN
            illegal_q   <= illegal_d;
`endif
        end else if (adv) begin
            out_valid_q <= 1'b0;
        end
    end

    // Stall cycle counter, saturating at all-ones.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            cnt_q <= '0;
        else if (hazard & ~bus.flush & (cnt_q != '1))
            cnt_q <= cnt_q + CNT_W'(1);
    end

    assign bus.in_ready      = in_ready;
    assign bus.rf_rs1        = rs1;
    assign bus.rf_rs2        = rs2;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_rs1       = dec_q.rs1;
    assign bus.out_rs2       = dec_q.rs2;
    assign bus.out_rd        = dec_q.rd;
    assign bus.out_opr_a     = dec_q.opr_a;
    assign bus.out_opr_b     = dec_q.opr_b;
    assign bus.out_imm       = dec_q.imm;
    assign bus.out_pc        = dec_q.pc;
    assign bus.out_pc4       = dec_q.pc4;
    assign bus.out_rf_en     = dec_q.rf_en;
    assign bus.out_dm_en     = dec_q.dm_en;
    assign bus.out_is_load   = dec_q.is_load;
    assign bus.out_is_branch = dec_q.is_branch;
    assign bus.out_is_jump   = dec_q.is_jump;
    assign bus.out_funct3    = dec_q.funct3;
    assign bus.out_opcode    = dec_q.opcode;
    assign bus.stall_cnt     = cnt_q;
`ifdef ID_ILLEGAL_DET_EN
    assign bus.out_illegal   = illegal_q;
`endif
endmodule

// File: tb/tb_id_decode_pipe.sv
// Directed bench for id_decode_pipe at XLEN=64, CNT_W=2.
module tb_id_decode_pipe;
    logic clk = 1'b0;
    logic arst_n = 1'b0;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    id_decode_pipe_if #(.XLEN(64), .CNT_W(2)) bus ();

    id_decode_pipe #(.XLEN(64), .WB_LOAD(2'b10), .CNT_W(2)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [4:0]  rd;
        logic [4:0]  ctl;   // {rf_en, dm_en, is_load, is_branch, is_jump}
    } vec_t;

    vec_t vt[12];
    logic [1:0] sat_exp[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] inst, input logic [63:0] pc);
        bus.in_valid = 1'b1;
        bus.in_inst  = inst;
        bus.in_pc    = pc;
    endtask

    task automatic ex_load(input logic v, input logic [4:0] rd, input logic [1:0] wb);
        bus.ex_valid  = v;
        bus.ex_rd     = rd;
        bus.ex_wb_sel = wb;
    endtask

    initial begin
        vt[0]  = '{32'hFFF00093, 64'h1000, 64'hFFFFFFFFFFFFFFFF, 5'd1,  5'b10000}; // addi x1,x0,-1
        vt[1]  = '{32'h0081A103, 64'h1004, 64'h8,                5'd2,  5'b11100}; // lw x2,8(x3)
        vt[2]  = '{32'hFE512E23, 64'h1008, 64'hFFFFFFFFFFFFFFFC, 5'd28, 5'b01000}; // sw x5,-4(x2)
        vt[3]  = '{32'hFE208CE3, 64'h100C, 64'hFFFFFFFFFFFFFFF8, 5'd25, 5'b00010}; // beq x1,x2,-8
        vt[4]  = '{32'h800002B7, 64'h1010, 64'hFFFFFFFF80000000, 5'd5,  5'b10000}; // lui x5,0x80000
        vt[5]  = '{32'h12345017, 64'h1014, 64'h12345000,         5'd0,  5'b00000}; // auipc x0
        vt[6]  = '{32'h001000EF, 64'h1018, 64'h800,              5'd1,  5'b10001}; // jal x1,2048
        vt[7]  = '{32'hFFFFF06F, 64'h101C, 64'hFFFFFFFFFFFFFFFE, 5'd0,  5'b00001}; // jal x0,-2
        vt[8]  = '{32'h010280E7, 64'h1020, 64'h10,               5'd1,  5'b10001}; // jalr x1,16(x5)
        vt[9]  = '{32'h00728333, 64'h1024, 64'h0,                5'd6,  5'b10000}; // add x6,x5,x7
        vt[10] = '{32'h0011819B, 64'h1028, 64'h1,                5'd3,  5'b10000}; // addiw x3,x3,1
        vt[11] = '{32'hFFFFF0FF, 64'hFFFFFFFFFFFFFFFC, 64'h0,    5'd1,  5'b00000}; // unknown opcode
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

        bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0;
        bus.rf_rdata1 = '0; bus.rf_rdata2 = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b1;
        ex_load(1'b0, 5'd0, 2'b00);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
        chk("rst_out_imm", bus.out_imm, 64'd0);
        chk("rst_out_pc", bus.out_pc, 64'd0);
        chk("rst_out_rd", 64'(bus.out_rd), 64'd0);
        chk("rst_out_rf_en", 64'(bus.out_rf_en), 64'd0);
        arst_n = 1'b1;
        @(negedge clk);

        // Decode table, back-to-back
        for (int i = 0; i < 12; i++) begin
            drive(vt[i].inst, vt[i].pc);
            bus.rf_rdata1 = {32'hA5A50000, 32'(i)};
            bus.rf_rdata2 = {32'h5A5A0000, 32'(i)};
            #1;
            chk($sformatf("v%0d_in_ready", i), 64'(bus.in_ready), 64'd1);
            chk($sformatf("v%0d_rf_rs1", i), 64'(bus.rf_rs1), 64'(vt[i].inst[19:15]));
            chk($sformatf("v%0d_rf_rs2", i), 64'(bus.rf_rs2), 64'(vt[i].inst[24:20]));
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), 64'(bus.out_valid), 64'd1);
            chk($sformatf("v%0d_imm", i), bus.out_imm, vt[i].imm);
            chk($sformatf("v%0d_rd", i), 64'(bus.out_rd), 64'(vt[i].rd));
            chk($sformatf("v%0d_ctl", i),
                64'({bus.out_rf_en, bus.out_dm_en, bus.out_is_load, bus.out_is_branch, bus.out_is_jump}),
                64'(vt[i].ctl));
            chk($sformatf("v%0d_pc", i), bus.out_pc, vt[i].pc);
            chk($sformatf("v%0d_pc4", i), bus.out_pc4, vt[i].pc + 64'd4);
            chk($sformatf("v%0d_opr", i), {bus.out_opr_a[31:0], bus.out_opr_b[31:0]},
                {32'(i), 32'(i)});
            chk($sformatf("v%0d_op_f3", i), 64'({bus.out_funct3, bus.out_opcode}),
                64'({vt[i].inst[14:12], vt[i].inst[6:0]}));
        end

        // Load-use hazard
        drive(32'h00728333, 64'h5000);            // add x6,x5,x7
        ex_load(1'b1, 5'd5, 2'b10);
        #1 chk("lu_in_ready_rs1", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        chk("lu_bubble", 64'(bus.out_valid), 64'd0);
        chk("lu_stall1", 64'(bus.stall_cnt), 64'd1);
        ex_load(1'b1, 5'd7, 2'b10);               // match on rs2
        #1 chk("lu_in_ready_rs2", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        chk("lu_stall2", 64'(bus.stall_cnt), 64'd2);
        ex_load(1'b1, 5'd5, 2'b01);               // not a load
        #1 chk("lu_nonload", 64'(bus.in_ready), 64'd1);
        ex_load(1'b1, 5'd0, 2'b10);               // x0 never hazards
        #1 chk("lu_rd0", 64'(bus.in_ready), 64'd1);
        drive(32'h123452B7, 64'h5000);            // lui: rs1 field = 8, unused
        ex_load(1'b1, 5'd8, 2'b10);
        #1 chk("lu_lui", 64'(bus.in_ready), 64'd1);
        drive(32'h00728333, 64'h5000);
        ex_load(1'b0, 5'd5, 2'b10);
        #1 chk("lu_release", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        chk("lu_accept_valid", 64'(bus.out_valid), 64'd1);
        chk("lu_accept_rs1", 64'(bus.out_rs1), 64'd5);
        chk("lu_stall_hold", 64'(bus.stall_cnt), 64'd2);

        // Back-pressure
        bus.in_valid = 1'b0;
        @(negedge clk);
        drive(32'h0081A103, 64'h2000);            // lw x2,8(x3)
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("bp_load_valid", 64'(bus.out_valid), 64'd1);
        drive(32'hFFF00093, 64'h3000);            // addi x1,x0,-1
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("bp%0d_in_ready", k), 64'(bus.in_ready), 64'd0);
            @(negedge clk);
            chk($sformatf("bp%0d_valid", k), 64'(bus.out_valid), 64'd1);
            chk($sformatf("bp%0d_imm", k), bus.out_imm, 64'h8);
            chk($sformatf("bp%0d_pc_rd", k), {bus.out_pc[58:0], bus.out_rd}, {59'h2000, 5'd2});
        end
        bus.out_ready = 1'b1;
        #1 chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        chk("bp_next_imm", bus.out_imm, 64'hFFFFFFFFFFFFFFFF);
        chk("bp_next_pc", bus.out_pc, 64'h3000);

        // Flush with a held instruction and a pending input
        drive(32'h001000EF, 64'h4000);
        bus.out_ready = 1'b0;
        bus.flush = 1'b1;
        #1 chk("fl_in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        chk("fl_valid", 64'(bus.out_valid), 64'd0);
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("fl_not_captured", 64'(bus.out_valid), 64'd0);
        drive(32'h00728333, 64'h5000);            // hazard under flush is not counted
        ex_load(1'b1, 5'd5, 2'b10);
        bus.flush = 1'b1;
        @(negedge clk);
        chk("fl_no_stall", 64'(bus.stall_cnt), 64'd2);
        bus.flush = 1'b0;

        // Saturation
        arst_n = 1'b0;
        #1 chk("sat_rst", 64'(bus.stall_cnt), 64'd0);
        arst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("sat%0d", k), 64'(bus.stall_cnt), 64'(sat_exp[k]));
        end
        chk("sat_bubble", 64'(bus.out_valid), 64'd0);

        // Asynchronous reset mid-cycle while holding an instruction
        ex_load(1'b0, 5'd0, 2'b00);
        @(negedge clk);
        chk("ar_pre_valid", 64'(bus.out_valid), 64'd1);
        #2 arst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(bus.out_valid), 64'd0);
        chk("ar_stall", 64'(bus.stall_cnt), 64'd0);
        chk("ar_rd", 64'(bus.out_rd), 64'd0);
        #1 arst_n = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/id_decode_pipe.md
Name: id_decode_pipe

Overview:
- Parametrised, registered instruction-decode stage between IF and EX; successor to the single-width combinational decode/immediate helper.
- Decodes RV32I/RV64I instructions and generates sign-extended XLEN immediates.
- Detects load-use hazards against EX and inserts bubbles.
- Holds one decoded instruction in an output register under a valid/ready handshake, and counts stall cycles.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- WB_LOAD, 2'b10, EX wb_sel encoding that marks a load.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock, rising edge.
- arst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  IF holds a valid instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- rf_rs1  out  5  register-file read address = in_inst[19:15] (combinational).
- rf_rs2  out  5  register-file read address = in_inst[24:20] (combinational).
- rf_rdata1  in  XLEN  read data for rf_rs1, same cycle.
- rf_rdata2  in  XLEN  read data for rf_rs2, same cycle.
- ex_valid  in  1  EX holds a valid instruction.
- ex_rd  in  5  EX destination register.
- ex_wb_sel  in  2  EX writeback select.
- flush  in  1  kill the ID contents and the current input (branch/jump taken).
- out_valid  out  1  decoded instruction valid.
- out_ready  in  1  EX accepts.
- out_rs1, out_rs2, out_rd  out  5 each  registered register indices.
- out_opr_a, out_opr_b  out  XLEN each  registered rf_rdata1 and rf_rdata2.
- out_imm  out  XLEN  registered immediate.
- out_pc  out  XLEN  registered PC.
- out_pc4  out  XLEN  registered in_pc+4.
- out_rf_en, out_dm_en, out_is_load, out_is_branch, out_is_jump  out  1 each  registered control.
- out_funct3  out  3  registered funct3.
- out_opcode  out  7  registered opcode.
- stall_cnt  out  CNT_W  hazard-stall cycle count.

Behaviour:
- Reset (arst_n=0, async): out_valid=0, all out_* data/control=0, stall_cnt=0. Reset mid-transfer discards the held instruction.
- Immediates:
  - I-type: OPIMM, LOAD, JALR, and OPIMM32 when XLEN=64.
  - S-type: STORE.
  - B-type: BRANCH, bit 0 = 0.
  - U-type: LUI, AUIPC, low 12 bits zero.
  - J-type: JAL, bit 0 = 0.
  - All are sign-extended from inst[31] to XLEN. U-type is also sign-extended above bit 31 when XLEN=64. Unknown opcode gives imm=0.
- Register use:
  - uses_rs1 for opcodes other than LUI, AUIPC, JAL.
  - uses_rs2 for OP, OP32, STORE, BRANCH.
- hazard = ex_valid & (ex_wb_sel==WB_LOAD) & (ex_rd!=0) & ((uses_rs1 & ex_rd==rs1) | (uses_rs2 & ex_rd==rs2)). It is evaluated only while in_valid=1.
- adv = ~out_valid | out_ready.
- in_ready = adv & ~hazard & ~flush.
- Each cycle, in priority order:
  1. flush: out_valid<=0, input dropped.
  2. in_valid & in_ready: output register loads the decoded instruction, out_valid<=1.
  3. adv (hazard, or no input): out_valid<=0, which inserts a bubble.
  4. Otherwise: hold every output unchanged.
- Latency is 1 cycle from accept to out_valid.
- While out_valid=1 & out_ready=0, all out_* stay stable.
- stall_cnt increments by 1 every cycle with in_valid & hazard & ~flush. It saturates at 2^CNT_W-1 and does not wrap.
- Control decode:
  - rf_en for all opcodes except STORE and BRANCH, and 0 when rd=0.
  - dm_en for LOAD and STORE.
  - is_jump for JAL and JALR.
- out_pc4 = in_pc+4, modulo 2^XLEN (wraps at the top of the address space).

Optional Feature:
- Macro ID_ILLEGAL_DET_EN.
- When defined:
  - Adds output out_illegal (1 bit, registered, reset 0).
  - out_illegal=1 for an unrecognised opcode, or for inst[1:0]!=2'b11.
  - When out_illegal=1, rf_en and dm_en are forced to 0.
- When not defined:
  - The port is absent.
  - Unknown opcodes decode as a NOP (imm=0, rf_en=0, dm_en=0) with no indication.

Test Plan:
- Reset: arst_n low mid-cycle with out_valid=1 -> out_valid=0 and stall_cnt=0 immediately, without waiting for a clock edge.
- Immediate: in_inst=0xFFF00093 (addi x1,x0,-1), XLEN=64 -> next cycle out_imm=0xFFFFFFFFFFFFFFFF, out_rd=1, out_rf_en=1, out_valid=1.
- Load-use: EX holds ex_valid=1, ex_rd=5, ex_wb_sel=2'b10; input is add x6,x5,x7:
  - in_ready=0, next cycle out_valid=0, stall_cnt=1.
  - Drop ex_valid -> accepted, out_rs1=5.
- Back-pressure: out_valid=1 with out_ready=0 for 3 cycles -> out_* unchanged, in_ready=0; out_ready=1 -> next instruction loads.
- Flush with in_valid=1 and out_valid=1 -> in_ready=0, next cycle out_valid=0, input not captured.
- Saturation: CNT_W=2, hazard held 6 cycles -> stall_cnt reads 1, 2, 3, 3, 3, 3.
